cpu_memory_stage: RTL and testbench

//  Pipeline memory stage between execute and writeback. Takes one execute result per
//  tag toggle, runs loads/stores on a single-outstanding data bus, and registers the

---
 rtl/cpu_memory_stage_if.sv | 28 ++
 rtl/cpu_memory_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_cpu_memory_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_memory_stage_if.sv
// Data-bus interface for the CPU memory stage.
// Single-outstanding request/ready bus:
//   request  master->slave  access pending; fields below held stable until ready
//   rw       master->slave  1=write, 0=read
//   address  master->slave  word-aligned byte address
//   byte_en  master->slave  active byte lanes
//   wdata    master->slave  lane-replicated store data
//   ready    slave->master  access completes this cycle
//   rdata    slave->master  read data, valid with ready on a read
interface cpu_memory_stage_if;
  logic        request;
  logic        rw;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output request, rw, address, byte_en, wdata,
    input  ready, rdata
  );

  modport slave (
    input  request, rw, address, byte_en, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/cpu_memory_stage.sv
// CPU pipeline memory stage between execute and writeback.
// Accepts one execute result per tag toggle, performs loads/stores over a
// single-outstanding data bus and registers the stage result (tag, inst_rd, rd)
// that the forwarding unit and writeback read.
// Ports:
//   i_clock, i_reset        clock, asynchronous active-low reset
//   i_tag .. i_mem_wdata    execute-stage result and memory operation
//   bus                     data bus (master side)
//   o_tag, o_inst_rd, o_rd  registered memory-stage result
//   o_busy                  stage cannot accept; upstream holds its outputs
//   o_fault                 one-cycle pulse on misaligned access or bus timeout
module cpu_memory_stage #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_tag,
  input  logic [4:0]                 i_inst_rd,
  input  logic [31:0]                i_rd,
  input  logic                       i_mem_read,
  input  logic                       i_mem_write,
  input  logic [1:0]                 i_mem_width,
  input  logic                       i_mem_signed,
  input  logic [31:0]                i_mem_address,
  input  logic [31:0]                i_mem_wdata,
  cpu_memory_stage_if.master         bus,
  output logic                       o_tag,
  output logic [4:0]                 o_inst_rd,
  output logic [31:0]                o_rd,
  output logic                       o_busy,
  output logic                       o_fault
);

  localparam int unsigned CntW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e state_q, state_d;

  // Stage result
  logic        tag_q, tag_d;
  logic [4:0]  inst_rd_q, inst_rd_d;
  logic [31:0] rd_q, rd_d;
  logic        fault_q, fault_d;

  // Bus request registers
  logic        req_q, req_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  // Pending instruction context
  logic        p_tag_q, p_tag_d;
  logic [4:0]  p_rd_q, p_rd_d;
  logic [1:0]  p_lane_q, p_lane_d;
  logic [1:0]  p_width_q, p_width_d;
  logic        p_signed_q, p_signed_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        mem_op;
  logic        aligned;
  logic        start_bus;
  logic        timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Extract and extend a sub-word load from the latched bus word.
  function automatic logic [31:0] load_extract(input logic [31:0] data,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  width,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(data >> {lane, 3'b000});
    h = lane[1] ? data[31:16] : data[15:0];
    case (width)
      2'd0:    load_extract = {{24{sgn & b[7]}}, b};
      2'd1:    load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = data;
    endcase
  endfunction

  assign accept  = (state_q == StIdle) && (i_tag != tag_q);
  assign mem_op  = i_mem_read | i_mem_write;
  always_comb begin
    case (i_mem_width)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~i_mem_address[0];
      default: aligned = (i_mem_address[1:0] == 2'b00);
    endcase
  end
  assign start_bus = accept && mem_op && aligned;

  // Counts BUS cycles without ready; the last allowed cycle with no ready aborts.
  assign timeout_hit = (BUS_TIMEOUT != 0) && (state_q == StBus) && !bus.ready &&
                       (cnt_q == CntW'(BUS_TIMEOUT - 1));

  always_comb begin
    case (i_mem_width)
      2'd0: begin
        be_calc    = 4'b0001 << i_mem_address[1:0];
        wdata_calc = {4{i_mem_wdata[7:0]}};
      end
      2'd1: begin
        be_calc    = i_mem_address[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{i_mem_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = i_mem_wdata;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start_bus) state_d = StBus;
      StBus: begin
        if (bus.ready) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath next state
  always_comb begin
    tag_d      = tag_q;
    inst_rd_d  = inst_rd_q;
    rd_d       = rd_q;
    fault_d    = 1'b0;
    req_d      = req_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    p_tag_d    = p_tag_q;
    p_rd_d     = p_rd_q;
    p_lane_d   = p_lane_q;
    p_width_d  = p_width_q;
    p_signed_d = p_signed_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    o_busy     = (state_q != StIdle) || start_bus;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (!mem_op) begin
            tag_d     = i_tag;
            inst_rd_d = i_inst_rd;
            rd_d      = (i_inst_rd == 5'd0) ? 32'd0 : i_rd;
          end else if (!aligned) begin
            tag_d     = i_tag;
            inst_rd_d = 5'd0;
            rd_d      = 32'd0;
            fault_d   = 1'b1;
          end else begin
            req_d      = 1'b1;
            rw_d       = i_mem_write;
            addr_d     = {i_mem_address[31:2], 2'b00};
            be_d       = be_calc;
            wdata_d    = wdata_calc;
            p_tag_d    = i_tag;
            p_rd_d     = i_mem_write ? 5'd0 : i_inst_rd;
            p_lane_d   = i_mem_address[1:0];
            p_width_d  = i_mem_width;
            p_signed_d = i_mem_signed;
            cnt_d      = '0;
          end
        end
      end
      StBus: begin
        if (bus.ready) begin
          req_d   = 1'b0;
          rdata_d = bus.rdata;
        end else if (timeout_hit) begin
          // Abort: complete like a misaligned access, no writeback.
          req_d     = 1'b0;
          fault_d   = 1'b1;
          tag_d     = p_tag_q;
          inst_rd_d = 5'd0;
          rd_d      = 32'd0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        tag_d     = p_tag_q;
        inst_rd_d = p_rd_q;
        rd_d      = (p_rd_q == 5'd0) ? 32'd0 :
                    load_extract(rdata_q, p_lane_q, p_width_q, p_signed_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tag_q      <= 1'b0;
      inst_rd_q  <= '0;
      rd_q       <= '0;
      fault_q    <= 1'b0;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      p_tag_q    <= 1'b0;
      p_rd_q     <= '0;
      p_lane_q   <= '0;
      p_width_q  <= '0;
      p_signed_q <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      tag_q      <= tag_d;
      inst_rd_q  <= inst_rd_d;
      rd_q       <= rd_d;
      fault_q    <= fault_d;
      req_q      <= req_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      p_tag_q    <= p_tag_d;
      p_rd_q     <= p_rd_d;
      p_lane_q   <= p_lane_d;
      p_width_q  <= p_width_d;
      p_signed_q <= p_signed_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.request = req_q;
  assign bus.rw      = rw_q;
  assign bus.address = addr_q;
  assign bus.byte_en = be_q;
  assign bus.wdata   = wdata_q;

  assign o_tag     = tag_q;
  assign o_inst_rd = inst_rd_q;
  assign o_rd      = rd_q;
  assign o_fault   = fault_q;

endmodule

// File: tb/tb_cpu_memory_stage.sv
module tb_cpu_memory_stage;

  logic        clk;
  logic        rst_n;
  logic        i_tag;
  logic [4:0]  i_inst_rd;
  logic [31:0] i_rd;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_mem_width;
  logic        i_mem_signed;
  logic [31:0] i_mem_address;
  logic [31:0] i_mem_wdata;
  logic        o_tag;
  logic [4:0]  o_inst_rd;
  logic [31:0] o_rd;
  logic        o_busy;
  logic        o_fault;

  int n_cmp = 0;
  int n_err = 0;

  cpu_memory_stage_if bus_if ();

  cpu_memory_stage #(
    .BUS_TIMEOUT (4)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_tag         (i_tag),
    .i_inst_rd     (i_inst_rd),
    .i_rd          (i_rd),
    .i_mem_read    (i_mem_read),
    .i_mem_write   (i_mem_write),
    .i_mem_width   (i_mem_width),
    .i_mem_signed  (i_mem_signed),
    .i_mem_address (i_mem_address),
    .i_mem_wdata   (i_mem_wdata),
    .bus           (bus_if.master),
    .o_tag         (o_tag),
    .o_inst_rd     (o_inst_rd),
    .o_rd          (o_rd),
    .o_busy        (o_busy),
    .o_fault       (o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic tag, input logic [4:0] rd_idx, input logic [31:0] val,
                        input logic rd_en, input logic wr_en, input logic [1:0] width,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    i_tag         = tag;
    i_inst_rd     = rd_idx;
    i_rd          = val;
    i_mem_read    = rd_en;
    i_mem_write   = wr_en;
    i_mem_width   = width;
    i_mem_signed  = sgn;
    i_mem_address = addr;
    i_mem_wdata   = wd;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.ready = 1'b0;
    bus_if.rdata = 32'd0;
    set_op(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    check_eq("rst_tag", 32'(o_tag), 32'd0);
    check_eq("rst_inst_rd", 32'(o_inst_rd), 32'd0);
    check_eq("rst_rd", o_rd, 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_fault", 32'(o_fault), 32'd0);
    check_eq("rst_req", 32'(bus_if.request), 32'd0);
    rst_n = 1'b1;
    step();

    // ALU pass-through
    set_op(1'b1, 5'd7, 32'h1234, 1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
    #1 check_eq("alu_busy", 32'(o_busy), 32'd0);
    step();
    check_eq("alu_tag", 32'(o_tag), 32'd1);
    check_eq("alu_inst_rd", 32'(o_inst_rd), 32'd7);
    check_eq("alu_rd", o_rd, 32'h1234);
    check_eq("alu_req", 32'(bus_if.request), 32'd0);

    // x0 destination forces result to zero
    set_op(1'b0, 5'd0, 32'hDEAD, 1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
    step();
    check_eq("x0_tag", 32'(o_tag), 32'd0);
    check_eq("x0_rd", o_rd, 32'd0);

    // Signed byte load at 0x103, ready on the third BUS cycle
    set_op(1'b1, 5'd5, 32'd0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
    #1 check_eq("lb_busy_accept", 32'(o_busy), 32'd1);
    step();                                   // BUS cycle 1
    check_eq("lb_req", 32'(bus_if.request), 32'd1);
    check_eq("lb_rw", 32'(bus_if.rw), 32'd0);
    check_eq("lb_addr", bus_if.address, 32'h100);
    check_eq("lb_be", 32'(bus_if.byte_en), 32'h8);
    check_eq("lb_tag_hold", 32'(o_tag), 32'd0);
    step();                                   // BUS cycle 2
    check_eq("lb_addr_hold", bus_if.address, 32'h100);
    step();                                   // BUS cycle 3
    bus_if.ready = 1'b1;
    bus_if.rdata = 32'h80123456;
    step();                                   // DONE
    bus_if.ready = 1'b0;
    bus_if.rdata = 32'd0;
    check_eq("lb_done_tag", 32'(o_tag), 32'd0);
    check_eq("lb_done_busy", 32'(o_busy), 32'd1);
    check_eq("lb_done_req", 32'(bus_if.request), 32'd0);
    step();                                   // 5 cycles after accept
    check_eq("lb_tag", 32'(o_tag), 32'd1);
    check_eq("lb_inst_rd", 32'(o_inst_rd), 32'd5);
    check_eq("lb_rd", o_rd, 32'hFFFFFF80);
    check_eq("lb_busy_clr", 32'(o_busy), 32'd0);

    // Unsigned half load at 0x106, ready immediately
    set_op(1'b0, 5'd8, 32'd0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h106, 32'd0);
    step();
    check_eq("lhu_be", 32'(bus_if.byte_en), 32'hC);
    bus_if.ready = 1'b1;
    bus_if.rdata = 32'hABCD1234;
    step();
    bus_if.ready = 1'b0;
    step();
    check_eq("lhu_tag", 32'(o_tag), 32'd0);
    check_eq("lhu_rd", o_rd, 32'h0000ABCD);

    // Half store at 0x202
    set_op(1'b1, 5'd9, 32'h55, 1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234BEEF);
    step();
    check_eq("sh_req", 32'(bus_if.request), 32'd1);
    check_eq("sh_rw", 32'(bus_if.rw), 32'd1);
    check_eq("sh_be", 32'(bus_if.byte_en), 32'hC);
    check_eq("sh_wdata", bus_if.wdata, 32'hBEEFBEEF);
    check_eq("sh_addr", bus_if.address, 32'h200);
    bus_if.ready = 1'b1;
    step();
    bus_if.ready = 1'b0;
    step();
    check_eq("sh_tag", 32'(o_tag), 32'd1);
    check_eq("sh_inst_rd", 32'(o_inst_rd), 32'd0);
    check_eq("sh_rd", o_rd, 32'd0);

    // Byte store data replication
    set_op(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h301, 32'hCAFE00A5);
    step();
    check_eq("sb_be", 32'(bus_if.byte_en), 32'h2);
    check_eq("sb_wdata", bus_if.wdata, 32'hA5A5A5A5);
    bus_if.ready = 1'b1;
    step();
    bus_if.ready = 1'b0;
    step();
    check_eq("sb_tag", 32'(o_tag), 32'd0);

    // Misaligned word load at 0x101
    set_op(1'b1, 5'd3, 32'h77, 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'd0);
    #1 check_eq("mis_busy", 32'(o_busy), 32'd0);
    step();
    check_eq("mis_fault", 32'(o_fault), 32'd1);
    check_eq("mis_req", 32'(bus_if.request), 32'd0);
    check_eq("mis_tag", 32'(o_tag), 32'd1);
    check_eq("mis_inst_rd", 32'(o_inst_rd), 32'd0);
    check_eq("mis_rd", o_rd, 32'd0);
    step();
    check_eq("mis_fault_pulse", 32'(o_fault), 32'd0);
    check_eq("mis_req_after", 32'(bus_if.request), 32'd0);

    // Ready outside BUS is ignored
    bus_if.ready = 1'b1;
    step();
    bus_if.ready = 1'b0;
    check_eq("idle_ready_tag", 32'(o_tag), 32'd1);
    check_eq("idle_ready_req", 32'(bus_if.request), 32'd0);

    // Bus timeout after 4 BUS cycles
    set_op(1'b0, 5'd4, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
    step();
    check_eq("to_req", 32'(bus_if.request), 32'd1);
    step();
    step();
    step();
    check_eq("to_req_c4", 32'(bus_if.request), 32'd1);
    check_eq("to_fault_c4", 32'(o_fault), 32'd0);
    step();
    check_eq("to_fault", 32'(o_fault), 32'd1);
    check_eq("to_req_drop", 32'(bus_if.request), 32'd0);
    check_eq("to_busy", 32'(o_busy), 32'd0);
    check_eq("to_tag", 32'(o_tag), 32'd0);
    check_eq("to_inst_rd", 32'(o_inst_rd), 32'd0);
    step();
    check_eq("to_fault_pulse", 32'(o_fault), 32'd0);

    // Reset asserted mid-access
    set_op(1'b1, 5'd6, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
    step();
    check_eq("rb_req", 32'(bus_if.request), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rb_req_async", 32'(bus_if.request), 32'd0);
    check_eq("rb_tag_async", 32'(o_tag), 32'd0);
    set_op(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    step();
    rst_n = 1'b1;
    bus_if.ready = 1'b1;
    bus_if.rdata = 32'h12345678;
    step();
    step();
    step();
    bus_if.ready = 1'b0;
    check_eq("rb_tag", 32'(o_tag), 32'd0);
    check_eq("rb_inst_rd", 32'(o_inst_rd), 32'd0);
    check_eq("rb_rd", o_rd, 32'd0);
    check_eq("rb_busy", 32'(o_busy), 32'd0);
    check_eq("rb_req_after", 32'(bus_if.request), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
